// File: rtl/btn_debounce_counter.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, one-cycle press /
// release / long-press pulses and an 8-bit wrapping press counter.
module btn_debounce_counter #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_PRESS_MS  = 1000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       clr_count,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LP_CYCLES = CLK_FREQ / 1000 * LONG_PRESS_MS;
  localparam int DB_W      = $clog2(DB_CYCLES);
  localparam int LP_W      = $clog2(LP_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST  = LP_W'(LP_CYCLES - 1);
  localparam logic            PIN_IDLE = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2;
  logic            w_s;
  logic [DB_W-1:0] r_db;
  logic [LP_W-1:0] r_hold;
  logic            r_lp_done;
  logic            r_level, r_press, r_rel, r_long;
  logic [7:0]      r_cnt;
  logic            w_press, w_rel, w_long, w_db_clr;

  // Synchronizer idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= PIN_IDLE;
      r_sync2 <= PIN_IDLE;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ PIN_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RELEASED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    w_rel       = 1'b0;
    w_long      = 1'b0;
    w_db_clr    = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_state_nxt = PRESS_CHK;
          w_db_clr    = 1'b1;
        end
      end
      PRESS_CHK: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
        end else if (r_db == DB_LAST) begin
          w_state_nxt = PRESSED;
          w_press     = 1'b1;
        end
      end
      PRESSED: begin
        w_long = (r_hold == LP_LAST) && !r_lp_done;
        if (!w_s) begin
          w_state_nxt = RELEASE_CHK;
          w_db_clr    = 1'b1;
        end
      end
      RELEASE_CHK: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
        end else if (r_db == DB_LAST) begin
          w_state_nxt = RELEASED;
          w_rel       = 1'b1;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db      <= '0;
      r_hold    <= '0;
      r_lp_done <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_rel     <= 1'b0;
      r_long    <= 1'b0;
      r_cnt     <= 8'd0;
    end else begin
      r_press <= w_press;
      r_rel   <= w_rel;
      r_long  <= w_long;

      if (w_press)    r_level <= 1'b1;
      else if (w_rel) r_level <= 1'b0;

      if (w_db_clr)
        r_db <= '0;
      else if (r_state == PRESS_CHK || r_state == RELEASE_CHK)
        r_db <= r_db + 1'b1;

      // Hold timer only advances in PRESSED, so a release glitch pauses it.
      if (w_press) begin
        r_hold    <= '0;
        r_lp_done <= 1'b0;
      end else if (r_state == PRESSED) begin
        if (r_hold != LP_LAST) r_hold <= r_hold + 1'b1;
        if (w_long)            r_lp_done <= 1'b1;
      end

      // Clear takes effect before the increment when both land together.
      if (w_press)        r_cnt <= (clr_count ? 8'd0 : r_cnt) + 8'd1;
      else if (clr_count) r_cnt <= 8'd0;
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_rel;
  assign long_pulse    = r_long;
  assign press_count   = r_cnt;

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Scoreboard bench: stimulus queues expected pulses (kind, cycle window,
// count, level); a negedge monitor pops and compares each pulse it sees.
module tb_btn_debounce_counter;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_in;
  logic       clr_count;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  typedef struct {
    int kind;
    int lo;
    int hi;
    int cnt;
    int lvl;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  exp_cnt = 0;

  btn_debounce_counter #(
    .CLK_FREQ      (4000),
    .DEBOUNCE_MS   (2),
    .LONG_PRESS_MS (10),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .clr_count    (clr_count),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int lo, input int hi, input int cnt, input int lvl);
    ev_t e;
    e.kind = kind; e.lo = lo; e.hi = hi; e.cnt = cnt; e.lvl = lvl;
    sbq.push_back(e);
  endtask

  // Drive on a negedge; the next posedge is edge 0, so the pulse is seen at cyc+11 nominal.
  task automatic do_press();
    @(negedge clk);
    btn_in = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    push(K_PRESS, cyc + 10, cyc + 12, exp_cnt, 1);
  endtask

  task automatic do_release();
    @(negedge clk);
    btn_in = 1'b1;
    push(K_REL, cyc + 10, cyc + 12, exp_cnt, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
  endtask

  // Monitor
  int  m_n;
  int  m_kind;
  ev_t m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      m_n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
      if (m_n > 1) chk("pulse_exclusive", m_n, 1);
      if (m_n != 0) begin
        m_kind = press_pulse ? K_PRESS : (release_pulse ? K_REL : K_LONG);
        if (sbq.size() == 0) begin
          chk("unexpected_pulse_kind", m_kind, -1);
        end else begin
          m_e = sbq.pop_front();
          chk("pulse_kind", m_kind, m_e.kind);
          n_cmp++;
          if (cyc < m_e.lo || cyc > m_e.hi) begin
            n_err++;
            $display("FAIL pulse_time: got cycle %0d expected %0d..%0d", cyc, m_e.lo, m_e.hi);
          end
          chk("press_count", int'(press_count), m_e.cnt);
          chk("btn_level", int'(btn_level), m_e.lvl);
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].hi) begin
        m_e = sbq.pop_front();
        chk("missing_pulse_kind", -1, m_e.kind);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; btn_in = 1'b1; clr_count = 1'b0;
    idle(3);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(press_pulse), 0);
    chk("rst_rel", int'(release_pulse), 0);
    chk("rst_long", int'(long_pulse), 0);
    chk("rst_count", int'(press_count), 0);
    rst_n = 1'b1;
    idle(5);

    // Bounce: 3 cycles pressed, 2 released, x10
    for (int r = 0; r < 10; r++) begin
      @(negedge clk); btn_in = 1'b0;
      idle(2);
      @(negedge clk); btn_in = 1'b1;
      idle(1);
    end
    idle(15);
    chk("bounce_level", int'(btn_level), 0);
    chk("bounce_count", int'(press_count), 0);

    // Clean press / release, no long press
    do_press();
    idle(19);
    do_release();
    idle(15);
    drain();
    chk("clean_level", int'(btn_level), 0);
    chk("clean_count", int'(press_count), 1);

    // Release glitch of 3 cycles while pressed
    do_press();
    idle(19);
    @(negedge clk); btn_in = 1'b1;
    idle(2);
    @(negedge clk); btn_in = 1'b0;
    idle(8);
    chk("glitch_level", int'(btn_level), 1);
    do_release();
    idle(15);
    drain();

    // Long press: held 60 cycles, long pulse 40 cycles after press pulse
    do_press();
    push(K_LONG, cyc + 50, cyc + 52, exp_cnt, 1);
    idle(59);
    do_release();
    idle(15);
    drain();
    chk("long_count", int'(press_count), 3);

    // clr alone
    @(negedge clk); clr_count = 1'b1;
    @(negedge clk); clr_count = 1'b0;
    exp_cnt = 0;
    chk("clr_alone", int'(press_count), 0);

    // 256 presses wrap to 0, the next gives 1
    for (int p = 0; p < 256; p++) begin
      do_press();
      idle(11);
      do_release();
      idle(11);
    end
    drain();
    chk("wrap_count", int'(press_count), 0);
    do_press(); idle(11); do_release(); idle(11);
    do_press(); idle(11); do_release(); idle(11);
    drain();
    chk("post_wrap_count", int'(press_count), 2);

    // clr coinciding with press confirmation: edge 10 follows the 10th negedge
    @(negedge clk);
    btn_in = 1'b0;
    exp_cnt = 1;
    push(K_PRESS, cyc + 10, cyc + 12, 1, 1);
    idle(9);
    @(negedge clk); clr_count = 1'b1;
    @(negedge clk); clr_count = 1'b0;
    chk("clr_with_press", int'(press_count), 1);
    idle(3);
    do_release();
    idle(15);
    drain();
    @(negedge clk); clr_count = 1'b1;
    @(negedge clk); clr_count = 1'b0;
    exp_cnt = 0;
    chk("clr_alone_2", int'(press_count), 0);

    // Reset mid-press with the button still held
    do_press();
    idle(15);
    chk("pre_reset_level", int'(btn_level), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_press", int'(press_pulse), 0);
    chk("midrst_rel", int'(release_pulse), 0);
    chk("midrst_long", int'(long_pulse), 0);
    chk("midrst_count", int'(press_count), 0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 1;
    push(K_PRESS, cyc + 10, cyc + 12, 1, 1);
    idle(15);
    chk("post_reset_count", int'(press_count), 1);
    do_release();
    idle(15);
    drain();

    while (sbq.size() != 0) begin
      m_e = sbq.pop_front();
      chk("leftover_pulse_kind", -1, m_e.kind);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce_counter.md
# btn_debounce_counter

Input-side companion to the LED output path: conditions one raw push-button (asynchronous, bouncing) into clean clock-domain events. It synchronizes and debounces the button, then emits one-cycle press, release and long-press pulses plus an 8-bit press counter. It sits between the board button pin and user logic that drives the LEDs.

## Interface
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- DEBOUNCE_MS, 20: stability time in ms. DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS, which must be ≥ 2.
- LONG_PRESS_MS, 1000: hold time for a long press. LP_CYCLES = CLK_FREQ/1000*LONG_PRESS_MS, which must be greater than DB_CYCLES.
- BTN_ACTIVE_LOW, 1: 1 means pin low = pressed; 0 means pin high = pressed.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- btn_in  in  1  raw button pin, asynchronous to clk
- clr_count  in  1  synchronous clear of press_count
- btn_level  out  1  debounced state, 1 = pressed
- press_pulse  out  1  one-cycle pulse on each confirmed press
- release_pulse  out  1  one-cycle pulse on each confirmed release
- long_pulse  out  1  one-cycle pulse when a press has been held LP_CYCLES
- press_count  out  8  count of confirmed presses, wraps 255→0

## Operation
- **Synchronizer:** 2-FF synchronizer on btn_in.
  - Both flops reset to the released pin level (1 when BTN_ACTIVE_LOW=1).
  - s = normalized synchronizer output (1 = pressed).
- **Debounce timer:** width is clog2(DB_CYCLES).
- **Hold timer:** width is clog2(LP_CYCLES).
- **FSM states:** RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is RELEASED.
  - RELEASED: s=1 → PRESS_CHK, debounce timer=0.
  - PRESS_CHK:
    - s=0 → RELEASED. The bounce is rejected and no outputs change.
    - Otherwise the debounce timer increments.
    - When timer==DB_CYCLES-1 and s=1 → PRESSED. Set btn_level=1, press_pulse=1 for one cycle, press_count+1, hold timer=0.
  - PRESSED:
    - The hold timer increments.
    - When it reaches LP_CYCLES-1, long_pulse=1 for one cycle. The timer then saturates, so there is at most one long_pulse per press.
    - s=0 → RELEASE_CHK, debounce timer=0.
  - RELEASE_CHK:
    - The hold timer is paused, not cleared.
    - s=1 → PRESSED. The glitch is ignored and no pulse is emitted.
    - When the debounce timer reaches DB_CYCLES-1 with s=0 → RELEASED. Set btn_level=0 and release_pulse=1 for one cycle.
- **Counter arithmetic:** 8-bit unsigned, modulo 256.
- **clr_count:** sets press_count to 0 on the next edge.
  - If clr_count coincides with a press confirmation, press_count becomes 1 (clear, then count).
- **Pulse exclusivity:** press_pulse, release_pulse and long_pulse are never high in the same cycle.
- **Reset mid-operation:** all state returns to reset values immediately.
  - A button still held when reset is released is seen as a new press.
  - It produces press_pulse after the full debounce.

## Timing
- **Reset values:** btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, press_count=0.
- **Outputs:** all outputs are registered; no combinational path from btn_in.
- **Press latency:** let edge 0 be the first clk edge that samples the new pressed level into FF1.
  - FSM enters PRESS_CHK at edge 2.
  - press_pulse and btn_level rise after edge DB_CYCLES+2.
  - press_count updates on the same edge.
  - Add +1 cycle tolerance for synchronizer metastability.
- **Release latency:** release_pulse and btn_level fall DB_CYCLES+2 edges after the release is sampled. The same +1 tolerance applies.
- **Long press:** long_pulse rises LP_CYCLES edges after press_pulse, counting only cycles spent in PRESSED.
- **Pulse width:** each pulse is exactly 1 cycle.

## Test plan
Parameters for all scenarios: CLK_FREQ=4000, DEBOUNCE_MS=2, LONG_PRESS_MS=10, BTN_ACTIVE_LOW=1. This gives DB_CYCLES=8 and LP_CYCLES=40.
- **Reset:** assert rst_n=0 mid-sequence → all outputs 0 within the same cycle. With btn_in held low through reset release, press_pulse occurs 10 (±1) cycles later and press_count=1.
- **Clean press/release:** btn_in 1→0 held 20 cycles, then 0→1 → press_pulse once at edge 10 (±1) and btn_level=1. Then release_pulse 10 (±1) cycles after release, btn_level=0, press_count=1, long_pulse never asserted.
- **Bounce rejection:** 0-pulses of 3 cycles separated by 2 cycles of 1, repeated 10 times → no pulses, btn_level stays 0, press_count=0. A release glitch of 3 cycles during PRESSED produces no release_pulse.
- **Long press:** hold pressed 60 cycles → exactly one long_pulse, 40 cycles after press_pulse. No second long_pulse. release_pulse follows the release.
- **Counter wrap and clear:** 256 clean presses → press_count=0 and the next press gives 1. Assert clr_count in the same cycle as a press confirmation → press_count=1. clr_count alone → press_count=0.
